seg7_mux_display: RTL and testbench
===================================

SEG7_MUX_DISPLAY -- requirements
Module: seg7_mux_display

Interface
REQ-001 Parameter REFRESH_DIV, default 50000, clock cycles each digit is driven per scan slot (legal >= 2).
REQ-002 Parameter GAP_CYCLES, default 64, cycles with all anodes off between slots (legal >= 1).
REQ-003 clk  input  1  single system clock, all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 fdig  input  4  BCD units digit from the binary-to-BCD converter.
REQ-006 sdig  input  4  BCD tens digit.
REQ-007 tdig  input  4  BCD hundreds digit.
REQ-008 rdy  input  1  one-cycle pulse; fdig/sdig/tdig valid in that cycle.
REQ-009 seg  output  7  active-low segments, seg[6:0] = g,f,e,d,c,b,a.
REQ-010 an  output  3  active-low anodes, an[0] units, an[1] tens, an[2] hundreds.
REQ-011 valid  output  1  high once a value has been captured and is being displayed.

Function
REQ-012 On rdy=1, digits SHALL be captured into a shadow register in that cycle; rdy=0 cycles ignore digit inputs.
REQ-013 Shadow SHALL transfer to the active register only at the first cycle of an ON phase; mid-slot captures never alter the digit being driven.
REQ-014 rdy coinciding with an ON-phase start SHALL display the newly captured value in that slot.
REQ-015 FSM states IDLE, ON, GAP; IDLE->ON on first capture; ON->GAP after REFRESH_DIV cycles; GAP->ON after GAP_CYCLES cycles; index advances 0->1->2->0 on GAP->ON.
REQ-016 In IDLE: an=3'b111, seg=7'h7F, valid=0.
REQ-017 In ON: exactly one anode low (per index) unless blanked per REQ-024; in GAP: an=3'b111, seg=7'h7F.
REQ-018 Encoding 0..9 SHALL be 40,79,24,30,19,12,02,78,00,10 (hex); nibbles 10..15 display dash 7'h3F.
REQ-019 seg and an SHALL be registered and change in the same cycle.
REQ-020 Slot counter width SHALL be clog2(max(REFRESH_DIV,GAP_CYCLES)); counter reloads at each phase change, no wrap glitch.
REQ-021 valid SHALL rise in the cycle the FSM leaves IDLE and stay high until reset.

Reset
REQ-022 rst_n low SHALL immediately force an=3'b111, seg=7'h7F, valid=0, state IDLE, index 0, counter 0, shadow/active registers 0.
REQ-023 Reset asserted mid-scan SHALL discard any pending shadow value; after release the block waits for a new rdy.

Configuration
REQ-024 Macro SEG7_LZ_BLANK_EN defined: hundreds slot blanked (anode off) when hundreds=0; tens slot blanked when hundreds=0 and tens=0; units never blanked; timing unchanged.
REQ-025 Macro undefined: all three digits always driven, zeros shown as 7'h40.

Structure
REQ-026 Package seg7_pkg SHALL hold state enum (IDLE, ON, GAP), segment constants SEG_BLANK=7'h7F, SEG_DASH=7'h3F, and the 0..9 encoding table.
REQ-027 Combinational sub-module bcd_to_seg7 (4-bit in, 7-bit out) SHALL implement REQ-018; instantiated once, fed by active digit mux.

Verification (REFRESH_DIV=4, GAP_CYCLES=2)
REQ-028 Reset then no rdy for 100 cycles -> an=111, seg=7F, valid=0 throughout.
REQ-029 rdy pulse with tdig=1,sdig=2,fdig=8 -> repeating pattern: an=110 seg=00 x4, gap x2, an=101 seg=24 x4, gap x2, an=011 seg=79 x4, gap x2; valid=1.
REQ-030 rdy with 0,0,7: LZ_BLANK_EN defined -> only an=110 seg=78 slots low, hundreds/tens slots an=111; undefined -> hundreds/tens show seg=40.
REQ-031 New rdy (tdig=2,sdig=5,fdig=5) in 2nd cycle of tens ON slot -> tens slot completes with old value; next hundreds slot shows seg=24.
REQ-032 rdy with fdig=4'hC -> units slot seg=3F; rst_n pulsed low mid-ON -> an=111, seg=7F, valid=0 same cycle, remains until next rdy.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and segment constants for the multiplexed 3-digit 7-segment display.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_e;

  typedef struct packed {
    logic [3:0] hun;
    logic [3:0] ten;
    logic [3:0] uni;
  } digits_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Active-low g..a patterns; element 0 is the rightmost entry.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-low segment decoder; non-BCD nibbles show a dash.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = SEG_DASH;
    if (bcd < 4'd10) seg_c = SEG_TABLE[bcd];
  end

endmodule

// File: rtl/seg7_mux_display.sv
// Time-multiplexed 3-digit 7-segment driver with shadow/active digit registers.
// Optional leading-zero blanking is enabled by defining SEG7_LZ_BLANK_EN.
module seg7_mux_display
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned GAP_CYCLES  = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] fdig,
  input  logic [3:0] sdig,
  input  logic [3:0] tdig,
  input  logic       rdy,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       valid
);

  localparam int unsigned CNT_MAX = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  digits_t       shadow_q, shadow_d;
  digits_t       active_q, active_d;
  logic          valid_q, valid_d;
  logic [6:0]    seg_q, seg_d;
  logic [2:0]    an_q, an_d;

  digits_t       in_digits;
  logic          load_on;
  logic [3:0]    cur_digit;
  logic [6:0]    cur_seg_c;
  logic          blank;

  assign in_digits = {tdig, sdig, fdig};

  // Phase sequencing, digit capture and shadow-to-active transfer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    active_d = active_q;
    valid_d  = valid_q;
    load_on  = 1'b0;

    if (rdy) shadow_d = in_digits;

    case (state_q)
      IDLE: begin
        if (rdy) begin
          state_d = ON;
          cnt_d   = '0;
          idx_d   = 2'd0;
          valid_d = 1'b1;
          load_on = 1'b1;
        end
      end
      ON: begin
        if (cnt_q == CW'(REFRESH_DIV - 1)) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GAP: begin
        if (cnt_q == CW'(GAP_CYCLES - 1)) begin
          state_d = ON;
          cnt_d   = '0;
          idx_d   = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
          load_on = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        idx_d   = 2'd0;
      end
    endcase

    // shadow_d already folds in a capture coinciding with the slot start
    if (load_on) active_d = shadow_d;
  end

  // Digit select for the slot being entered next cycle.
  always_comb begin
    case (idx_d)
      2'd0:    cur_digit = active_d.uni;
      2'd1:    cur_digit = active_d.ten;
      default: cur_digit = active_d.hun;
    endcase
  end

  bcd_to_seg7 u_dec (
    .bcd   (cur_digit),
    .seg_c (cur_seg_c)
  );

  always_comb begin
`ifdef SEG7_LZ_BLANK_EN
    blank = ((idx_d == 2'd2) && (active_d.hun == 4'd0)) ||
            ((idx_d == 2'd1) && (active_d.hun == 4'd0) && (active_d.ten == 4'd0));
`else
    blank = 1'b0;
`endif
  end

  // Outputs are derived from next-cycle state so seg/an flip together with the phase.
  always_comb begin
    seg_d = SEG_BLANK;
    an_d  = 3'b111;
    if ((state_d == ON) && !blank) begin
      seg_d = cur_seg_c;
      an_d  = ~(3'b001 << idx_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= 2'd0;
      shadow_q <= '0;
      active_q <= '0;
      valid_q  <= 1'b0;
      seg_q    <= SEG_BLANK;
      an_q     <= 3'b111;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      valid_q  <= valid_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  assign seg   = seg_q;
  assign an    = an_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_seg7_mux_display.sv
// Scoreboard bench for seg7_mux_display with a 4-cycle slot and 2-cycle gap.
module tb_seg7_mux_display;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] fdig = 4'd0;
  logic [3:0] sdig = 4'd0;
  logic [3:0] tdig = 4'd0;
  logic       rdy = 1'b0;
  logic [6:0] seg;
  logic [2:0] an;
  logic       valid;

  int checks = 0;
  int errors = 0;

  logic [10:0] exp_q[$];
  string       name_q[$];
  logic [10:0] exp_e;
  string       exp_n;

  seg7_mux_display #(.REFRESH_DIV(4), .GAP_CYCLES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fdig  (fdig),
    .sdig  (sdig),
    .tdig  (tdig),
    .rdy   (rdy),
    .seg   (seg),
    .an    (an),
    .valid (valid)
  );

  always #5 clk = ~clk;

  // Monitor: one expectation is consumed per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_e = exp_q.pop_front();
      exp_n = name_q.pop_front();
      checks++;
      if (valid !== exp_e[10] || an !== exp_e[9:7] || seg !== exp_e[6:0]) begin
        errors++;
        $display("FAIL %s @%0t: got an=%b seg=%h valid=%b, want an=%b seg=%h valid=%b",
                 exp_n, $time, an, seg, valid, exp_e[9:7], exp_e[6:0], exp_e[10]);
      end
    end
  end

  task automatic push(input string nm, input logic [2:0] a, input logic [6:0] s, input logic v);
    exp_q.push_back({v, a, s});
    name_q.push_back(nm);
  endtask

  task automatic cyc(input string nm, input logic [2:0] a, input logic [6:0] s, input logic v);
    @(posedge clk);
    #1;
    rdy = 1'b0;
    push(nm, a, s, v);
  endtask

  task automatic cyc_rdy(input string nm, input logic [2:0] a, input logic [6:0] s, input logic v,
                         input logic [3:0] t, input logic [3:0] sd, input logic [3:0] f);
    @(posedge clk);
    #1;
    push(nm, a, s, v);
    rdy  = 1'b1;
    tdig = t;
    sdig = sd;
    fdig = f;
  endtask

  task automatic slot(input string nm, input logic [2:0] a, input logic [6:0] s, input int n);
    repeat (n) cyc(nm, a, s, 1'b1);
  endtask

  task automatic gap(input string nm);
    slot(nm, 3'b111, 7'h7F, 2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held, then 100 idle cycles with no rdy
    repeat (3) cyc("reset_hold", 3'b111, 7'h7F, 1'b0);
    rst_n = 1'b1;
    repeat (100) cyc("idle_no_rdy", 3'b111, 7'h7F, 1'b0);

    // Value 128: units 8, tens 2, hundreds 1, scanned twice around
    cyc_rdy("pre_rdy_idle", 3'b111, 7'h7F, 1'b0, 4'd1, 4'd2, 4'd8);
    slot("u8", 3'b110, 7'h00, 4);  gap("gap_a");
    slot("t2", 3'b101, 7'h24, 4);  gap("gap_b");
    slot("h1", 3'b011, 7'h79, 4);  gap("gap_c");
    slot("u8_wrap", 3'b110, 7'h00, 4); gap("gap_d");

    // Mid-slot capture of 255 during the tens slot
    cyc("t2_first", 3'b101, 7'h24, 1'b1);
    cyc_rdy("t2_second", 3'b101, 7'h24, 1'b1, 4'd2, 4'd5, 4'd5);
    slot("t2_keep_old", 3'b101, 7'h24, 2); gap("gap_e");
    slot("h2_new", 3'b011, 7'h24, 4); gap("gap_f");
    slot("u5_new", 3'b110, 7'h12, 4); gap("gap_g");
    slot("t5_new", 3'b101, 7'h12, 4); gap("gap_h");

    // Non-BCD units nibble shows a dash
    cyc_rdy("h2_hold", 3'b011, 7'h24, 1'b1, 4'd4, 4'd3, 4'hC);
    slot("h2_hold", 3'b011, 7'h24, 3); gap("gap_i");
    slot("u_dash", 3'b110, 7'h3F, 4); gap("gap_j");
    slot("h4", 3'b011, 7'h19, 0);
    cyc("t3", 3'b101, 7'h30, 1'b1);
    cyc_rdy("t3_pending", 3'b101, 7'h30, 1'b1, 4'd9, 4'd9, 4'd9);

    // Async reset mid-ON discards the pending 999
    @(posedge clk);
    #1;
    rdy   = 1'b0;
    rst_n = 1'b0;
    push("reset_mid_on", 3'b111, 7'h7F, 1'b0);
    cyc("reset_low", 3'b111, 7'h7F, 1'b0);
    rst_n = 1'b1;
    repeat (20) cyc("post_reset_idle", 3'b111, 7'h7F, 1'b0);

    // Value 007, then rdy coinciding with a slot start loads 009
    cyc_rdy("pre_rdy_007", 3'b111, 7'h7F, 1'b0, 4'd0, 4'd0, 4'd7);
    slot("u7", 3'b110, 7'h78, 4); gap("gap_k");
`ifdef SEG7_LZ_BLANK_EN
    slot("t0_blank", 3'b111, 7'h7F, 4); gap("gap_l");
    slot("h0_blank", 3'b111, 7'h7F, 4);
`else
    slot("t0_shown", 3'b101, 7'h40, 4); gap("gap_l");
    slot("h0_shown", 3'b011, 7'h40, 4);
`endif
    cyc("gap_m", 3'b111, 7'h7F, 1'b1);
    cyc_rdy("gap_m_rdy", 3'b111, 7'h7F, 1'b1, 4'd0, 4'd0, 4'd9);
    slot("u9_same_slot", 3'b110, 7'h10, 4); gap("gap_n");
`ifdef SEG7_LZ_BLANK_EN
    slot("t0_blank_b", 3'b111, 7'h7F, 4);
`else
    slot("t0_shown_b", 3'b101, 7'h40, 4);
`endif
    gap("gap_o");

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
